// File: rtl/motion_compensator_pkg.sv
// Shared definitions for the motion estimation / compensation pipeline:
// FSM states, macroblock geometry and residual width.
package motion_compensator_pkg;

  localparam int MB_SIZE_DEF = 16;
  localparam int PIX_W_DEF   = 8;
  localparam int MB_PIXELS   = MB_SIZE_DEF * MB_SIZE_DEF;
  localparam int IDX_W       = $clog2(MB_PIXELS);
  localparam int RES_W       = PIX_W_DEF + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FETCH = 2'd2,
    DONE  = 2'd3
  } mc_state_t;

  // Residual width for a given pixel width (cur - ref needs one extra sign bit).
  function automatic int res_width(input int pix_w);
    return pix_w + 1;
  endfunction

endpackage

// File: rtl/motion_compensator_res_skid_fifo.sv
// Two-entry synchronous FIFO holding {last, residual} words between the
// reference-read return path and the ready/valid output.
module res_skid_fifo #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/motion_compensator.sv
// Motion compensator: buffers one current macroblock, fetches the motion-displaced
// reference block and streams signed residuals (cur - ref) with backpressure.
module motion_compensator
  import motion_compensator_pkg::*;
#(
  parameter int MB_SIZE      = MB_SIZE_DEF,
  parameter int PIX_W        = PIX_W_DEF,
  parameter int ADDR_W       = 32,
  parameter int MV_W         = 16,
  parameter int FRAME_STRIDE = 1920
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mv_valid,
  output logic              mv_ready,
  input  logic [MV_W-1:0]   mv_x,
  input  logic [MV_W-1:0]   mv_y,
  input  logic [ADDR_W-1:0] ref_base_addr,
  input  logic [PIX_W-1:0]  cur_pixel_in,
  input  logic              cur_pixel_valid,
  output logic              cur_ready,
  output logic [ADDR_W-1:0] ref_addr,
  output logic              ref_rd,
  input  logic [PIX_W-1:0]  ref_pixel_in,
  output logic [PIX_W:0]    res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_last,
  output logic              done
);

  localparam int NPIX = MB_SIZE * MB_SIZE;
  localparam int IW   = $clog2(NPIX);
  localparam int CW   = $clog2(MB_SIZE);
  localparam int RW   = res_width(PIX_W);

  mc_state_t state;
  mc_state_t state_next;

  logic [ADDR_W-1:0] mv_x_q;
  logic [ADDR_W-1:0] mv_y_q;
  logic [ADDR_W-1:0] base_q;

  logic [PIX_W-1:0]  cur_buf [NPIX];
  logic [IW-1:0]     load_idx;

  logic [CW-1:0]     row;
  logic [CW-1:0]     col;
  logic [IW-1:0]     issue_idx;
  logic              issue_done;

  logic              rd_pending;
  logic [IW-1:0]     rd_idx;

  logic              fifo_push;
  logic              fifo_pop;
  logic [RW:0]       fifo_push_data;
  logic [RW:0]       fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;

  logic [2:0]        committed;
  logic              credit;
  logic              pixel_write;
  logic              load_last;
  logic [RW-1:0]     residual;
  logic [ADDR_W-1:0] row_off;
  logic [ADDR_W-1:0] col_off;
  logic [ADDR_W-1:0] fetch_addr;

  assign pixel_write = cur_ready && cur_pixel_valid;
  assign load_last   = pixel_write && (load_idx == IW'(NPIX - 1));

  // Slots already promised to the FIFO once this cycle's pop is accounted for;
  // counting the pop keeps one issue per cycle under continuous res_ready.
  assign fifo_pop  = res_valid && res_ready;
  assign committed = {1'b0, fifo_count} + {2'b00, rd_pending} - {2'b00, fifo_pop};
  assign credit    = (committed < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mv_ready   = 1'b0;
    cur_ready  = 1'b0;
    ref_rd     = 1'b0;
    done       = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          mv_ready = 1'b1;
          if (mv_valid) state_next = LOAD;
        end
        LOAD: begin
          cur_ready = 1'b1;
          if (cur_pixel_valid && (load_idx == IW'(NPIX - 1))) state_next = FETCH;
        end
        FETCH: begin
          ref_rd = !issue_done && credit;
          if (fifo_pop && fifo_head[RW]) state_next = DONE;
        end
        DONE: begin
          done       = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Motion vector capture, load index and raster-order read issue counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      mv_x_q     <= '0;
      mv_y_q     <= '0;
      base_q     <= '0;
      load_idx   <= '0;
      row        <= '0;
      col        <= '0;
      issue_idx  <= '0;
      issue_done <= 1'b0;
      rd_pending <= 1'b0;
      rd_idx     <= '0;
    end else begin
      rd_pending <= ref_rd;
      if (ref_rd) rd_idx <= issue_idx;

      if (mv_valid && mv_ready) begin
        mv_x_q   <= {{(ADDR_W - MV_W){mv_x[MV_W-1]}}, mv_x};
        mv_y_q   <= {{(ADDR_W - MV_W){mv_y[MV_W-1]}}, mv_y};
        base_q   <= ref_base_addr;
        load_idx <= '0;
      end else if (pixel_write) begin
        load_idx <= load_idx + IW'(1);
      end

      if (load_last) begin
        row        <= '0;
        col        <= '0;
        issue_idx  <= '0;
        issue_done <= 1'b0;
      end else if (ref_rd) begin
        issue_idx <= issue_idx + IW'(1);
        if (col == CW'(MB_SIZE - 1)) begin
          col <= '0;
          row <= row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (issue_idx == IW'(NPIX - 1)) issue_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pixel_write) cur_buf[load_idx] <= cur_pixel_in;
  end

  // Addresses wrap modulo 2^ADDR_W; the caller keeps the window inside the frame.
  assign row_off    = mv_y_q + ADDR_W'(row);
  assign col_off    = mv_x_q + ADDR_W'(col);
  assign fetch_addr = base_q + row_off * ADDR_W'(FRAME_STRIDE) + col_off;
  assign ref_addr   = ref_rd ? fetch_addr : '0;

  assign residual       = {1'b0, cur_buf[rd_idx]} - {1'b0, ref_pixel_in};
  assign fifo_push      = rd_pending && (!fifo_full || fifo_pop);
  assign fifo_push_data = {(rd_idx == IW'(NPIX - 1)), residual};

  res_skid_fifo #(
    .W(RW + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data(fifo_push_data),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign res_valid = !fifo_empty;
  assign res_data  = fifo_head[RW-1:0];
  assign res_last  = fifo_head[RW] && !fifo_empty;

endmodule
